// File: rtl/execute_stage.sv
// Execute stage of the 5-stage MIPS-subset pipeline.
// Resolves forwarded operands, runs the single-cycle ALU or a 32-iteration
// shift-add multiplier, and owns the execute/memory pipeline register.
module execute_stage (
  input  logic        clk,
  input  logic        rst_n,
  // control from the D/E register
  input  logic        regwriteE,
  input  logic        memtoregE,
  input  logic        memwriteE,
  input  logic [2:0]  alucontrolE,
  input  logic        mulE,
  input  logic        alusrcE,
  input  logic        regdstE,
  // operands from the D/E register
  input  logic [31:0] rd1E,
  input  logic [31:0] rd2E,
  input  logic [31:0] signimmE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  rdE,
  // hazard unit
  input  logic [1:0]  forwardAE,
  input  logic [1:0]  forwardBE,
  input  logic [31:0] resultW,
  input  logic        flushE,
  output logic        stallE,
  // E/M pipeline register
  output logic        regwriteM,
  output logic        memtoregM,
  output logic        memwriteM,
  output logic [31:0] aluoutM,
  output logic [31:0] writedataM,
  output logic [4:0]  writeregM
);

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Forwarding select codes; 2'b11 falls back to the register file
  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_e;

  // Everything the memory stage receives, kept together so a bubble is '0
  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [4:0]  writereg;
  } em_reg_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mul_state_e  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  em_reg_t     mul_ctrl_q, mul_ctrl_d;   // controls/dest/store data latched at accept
  em_reg_t     m_q, m_d;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic [4:0]  writereg_e;
  logic        stall;

  // Operand forwarding; aluoutM is the registered output fed back from M
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    src_a = rd1E;
    fwd_b = rd2E;
    case (forwardAE)
      FWD_W:   src_a = resultW;
      FWD_M:   src_a = m_q.aluout;
      default: src_a = rd1E;
    endcase
    case (forwardBE)
      FWD_W:   fwd_b = resultW;
      FWD_M:   fwd_b = m_q.aluout;
      default: fwd_b = rd2E;
    endcase
  end

  assign src_b      = alusrcE ? signimmE : fwd_b;
  assign writereg_e = regdstE ? rdE : rtE;

  // Single-cycle ALU; unsupported codes produce zero
  always_comb begin
    alu_result = 32'd0;
    case (alucontrolE)
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_SLT: alu_result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiplier FSM: next state, iteration datapath and stall
  // ---------------------------------------------------------------------------
  // Accept in IDLE, iterate 32 times in BUSY, hand the product to M in DONE
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    mul_ctrl_d = mul_ctrl_q;
    stall      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mulE && !flushE) begin
          // Operands are captured here so later forwarding changes cannot
          // disturb the product while upstream is stalled.
          stall                = 1'b1;
          mcand_d              = src_a;
          mplier_d             = src_b;
          acc_d                = 32'd0;
          count_d              = 5'd0;
          mul_ctrl_d.regwrite  = regwriteE;
          mul_ctrl_d.memtoreg  = memtoregE;
          mul_ctrl_d.memwrite  = memwriteE;
          mul_ctrl_d.aluout    = 32'd0;
          mul_ctrl_d.writedata = fwd_b;
          mul_ctrl_d.writereg  = writereg_e;
          state_d              = BUSY;
        end
      end

      BUSY: begin
        stall = 1'b1;
        if (flushE) begin
          // Abort: partial product is simply abandoned
          state_d = IDLE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // Stall already released; M captures the product this cycle
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stallE = stall;

  // ---------------------------------------------------------------------------
  // E/M register next value: bubble, finished product, or ALU result
  // ---------------------------------------------------------------------------
  // Priority: kill/stall bubble, then multiply completion, then normal ALU op
  always_comb begin
    m_d = '0;
    if (flushE || stall) begin
      m_d = '0;
    end else if (state_q == DONE) begin
      m_d        = mul_ctrl_q;
      m_d.aluout = acc_q;
    end else begin
      m_d.regwrite  = regwriteE;
      m_d.memtoreg  = memtoregE;
      m_d.memwrite  = memwriteE;
      m_d.aluout    = alu_result;
      m_d.writedata = fwd_b;
      m_d.writereg  = writereg_e;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Multiplier state and operand latches
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= 5'd0;
      mcand_q    <= 32'd0;
      mplier_q   <= 32'd0;
      acc_q      <= 32'd0;
      mul_ctrl_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      mul_ctrl_q <= mul_ctrl_d;
    end
  end

  // Execute/memory pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
    end else begin
      m_q <= m_d;
    end
  end

  assign regwriteM  = m_q.regwrite;
  assign memtoregM  = m_q.memtoreg;
  assign memwriteM  = m_q.memwrite;
  assign aluoutM    = m_q.aluout;
  assign writedataM = m_q.writedata;
  assign writeregM  = m_q.writereg;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases with literal
// expectations plus randomized traffic against a cycle-level reference model.
module tb_execute_stage;

  logic        clk;
  logic        rst_n;
  logic        regwriteE, memtoregE, memwriteE;
  logic [2:0]  alucontrolE;
  logic        mulE, alusrcE, regdstE;
  logic [31:0] rd1E, rd2E, signimmE;
  logic [4:0]  rtE, rdE;
  logic [1:0]  forwardAE, forwardBE;
  logic [31:0] resultW;
  logic        flushE;
  logic        stallE;
  logic        regwriteM, memtoregM, memwriteM;
  logic [31:0] aluoutM, writedataM;
  logic [4:0]  writeregM;

  execute_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .regwriteE   (regwriteE),
    .memtoregE   (memtoregE),
    .memwriteE   (memwriteE),
    .alucontrolE (alucontrolE),
    .mulE        (mulE),
    .alusrcE     (alusrcE),
    .regdstE     (regdstE),
    .rd1E        (rd1E),
    .rd2E        (rd2E),
    .signimmE    (signimmE),
    .rtE         (rtE),
    .rdE         (rdE),
    .forwardAE   (forwardAE),
    .forwardBE   (forwardBE),
    .resultW     (resultW),
    .flushE      (flushE),
    .stallE      (stallE),
    .regwriteM   (regwriteM),
    .memtoregM   (memtoregM),
    .memwriteM   (memwriteM),
    .aluoutM     (aluoutM),
    .writedataM  (writedataM),
    .writeregM   (writeregM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: what M must hold, and where a multiply stands
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
  } m_t;

  m_t m_exp = '0;      // expected M register contents
  m_t pend  = '0;      // finished multiply result waiting to retire
  int phase = 0;       // 0 idle, 1..32 iterating, 33 result ready
  int stall_seen = 0;  // DUT stall cycles observed (for latency checks)

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'b01) return resultW;
    if (sel == 2'b10) return m_exp.alu;
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    if (op == 3'b010) return a + b;
    if (op == 3'b110) return a - b;
    if (op == 3'b000) return a & b;
    if (op == 3'b001) return a | b;
    if (op == 3'b111) return (sa < sb) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  task automatic check_m(input string tag);
    check({tag, ".regwriteM"},  {31'd0, regwriteM}, {31'd0, m_exp.rw});
    check({tag, ".memtoregM"},  {31'd0, memtoregM}, {31'd0, m_exp.mtr});
    check({tag, ".memwriteM"},  {31'd0, memwriteM}, {31'd0, m_exp.mw});
    check({tag, ".aluoutM"},    aluoutM,            m_exp.alu);
    check({tag, ".writedataM"}, writedataM,         m_exp.wd);
    check({tag, ".writeregM"},  {27'd0, writeregM}, {27'd0, m_exp.wr});
  endtask

  // One clock cycle. Entered shortly after a rising edge with the inputs
  // already driven; returns 1 time unit after the next rising edge.
  task automatic step();
    logic [31:0] a, fb, b;
    logic        exp_stall;
    m_t          nxt;
    int          ph_n;
    #3;
    a  = fwd(forwardAE, rd1E);
    fb = fwd(forwardBE, rd2E);
    b  = alusrcE ? signimmE : fb;
    exp_stall = (phase == 0 && mulE && !flushE) || (phase >= 1 && phase <= 32);
    check("stallE", {31'd0, stallE}, {31'd0, exp_stall});
    if (stallE) stall_seen++;

    if (flushE || exp_stall) nxt = '0;
    else if (phase == 33)    nxt = pend;
    else begin
      nxt.rw  = regwriteE;
      nxt.mtr = memtoregE;
      nxt.mw  = memwriteE;
      nxt.alu = alu_ref(alucontrolE, a, b);
      nxt.wd  = fb;
      nxt.wr  = regdstE ? rdE : rtE;
    end

    ph_n = phase;
    if (flushE) ph_n = 0;
    else if (phase == 0) begin
      if (mulE) begin
        ph_n     = 1;
        pend.rw  = regwriteE;
        pend.mtr = memtoregE;
        pend.mw  = memwriteE;
        pend.alu = a * b;           // low 32 bits of the product
        pend.wd  = fb;
        pend.wr  = regdstE ? rdE : rtE;
      end
    end else if (phase == 33) ph_n = 0;
    else ph_n = phase + 1;

    @(posedge clk);
    if (!rst_n) begin
      phase = 0;
      m_exp = '0;
    end else begin
      phase = ph_n;
      m_exp = nxt;
    end
    #1;
    check_m("m");
  endtask

  task automatic randomize_inputs();
    regwriteE   = 1'($urandom);
    memtoregE   = 1'($urandom);
    memwriteE   = 1'($urandom);
    alucontrolE = 3'($urandom);
    mulE        = ($urandom_range(0, 7) == 0);
    alusrcE     = 1'($urandom);
    regdstE     = 1'($urandom);
    rd1E        = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
    rd2E        = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
    signimmE    = $urandom;
    rtE         = 5'($urandom);
    rdE         = 5'($urandom);
    forwardAE   = 2'($urandom);
    forwardBE   = 2'($urandom);
    resultW     = $urandom;
    flushE      = ($urandom_range(0, 63) == 0);
  endtask

  task automatic set_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    regwriteE = 1'b1; memtoregE = 1'b0; memwriteE = 1'b0;
    alucontrolE = op; mulE = 1'b0; alusrcE = 1'b0; regdstE = 1'b1;
    rd1E = a; rd2E = b; signimmE = 32'd0; rtE = 5'd3; rdE = 5'd9;
    forwardAE = 2'b00; forwardBE = 2'b00; flushE = 1'b0;
  endtask

  // Issue a multiply held in D/E for the whole stall; returns after the edge
  // that retires it. perturb scrambles forwarding inputs after accept.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit perturb,
                        output int stalls, output int rw_pulses);
    set_alu(3'b010, a, b);
    mulE = 1'b1;
    rdE  = 5'd17;
    stall_seen = 0;
    rw_pulses  = 0;
    step();                          // accept edge
    if (regwriteM) rw_pulses++;
    for (int i = 1; i <= 33; i++) begin
      if (perturb) begin
        resultW   = $urandom;
        forwardAE = 2'($urandom);
        forwardBE = 2'($urandom);
      end
      step();
      if (i <= 32 && regwriteM) rw_pulses++;
    end
    stalls = stall_seen;
    set_alu(3'b010, 32'd0, 32'd0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    phase = 0;
    m_exp = '0;
    check("rst.aluoutM", aluoutM, 32'd0);
    check("rst.regwriteM", {31'd0, regwriteM}, 32'd0);
    check("rst.writeregM", {27'd0, writeregM}, 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int stalls, pulses;
    rst_n = 1'b0;
    randomize_inputs();

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      step();
      randomize_inputs();
    end
    check("reset.aluoutM", aluoutM, 32'd0);

    // Release and first add
    rst_n = 1'b1;
    set_alu(3'b010, 32'd5, 32'd7);
    step();
    check("add.aluoutM", aluoutM, 32'd12);
    check("add.writeregM", {27'd0, writeregM}, 32'd9);

    // ALU sweep
    set_alu(3'b110, 32'd3, 32'd5);                 step();
    check("sub", aluoutM, 32'hFFFF_FFFE);
    set_alu(3'b111, 32'hFFFF_FFFF, 32'd1);         step();
    check("slt_neg", aluoutM, 32'd1);
    set_alu(3'b111, 32'd1, 32'hFFFF_FFFF);         step();
    check("slt_pos", aluoutM, 32'd0);
    set_alu(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0); step();
    check("and", aluoutM, 32'h00F0_00F0);
    set_alu(3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0); step();
    check("or", aluoutM, 32'hFFF0_FFF0);
    set_alu(3'b011, 32'h1234_5678, 32'h1111_1111); step();
    check("undef_op", aluoutM, 32'd0);

    // Forwarding
    set_alu(3'b010, 32'd60, 32'd40);               step();
    check("fwd.setup", aluoutM, 32'd100);
    set_alu(3'b010, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    forwardAE = 2'b10; forwardBE = 2'b01; resultW = 32'd23;
    step();
    check("fwd.add", aluoutM, 32'd123);
    set_alu(3'b010, 32'd1000, 32'hBAD0_BAD0);
    regwriteE = 1'b0; memwriteE = 1'b1; alusrcE = 1'b1; signimmE = 32'd4;
    forwardBE = 2'b01; resultW = 32'd23;
    step();
    check("store.aluoutM", aluoutM, 32'd1004);
    check("store.writedataM", writedataM, 32'd23);
    check("store.memwriteM", {31'd0, memwriteM}, 32'd1);

    // Multiply latency and products
    do_mul(32'h0001_0003, 32'h0000_0005, 1'b0, stalls, pulses);
    check("mul1.product", aluoutM, 32'h0005_000F);
    check("mul1.writeregM", {27'd0, writeregM}, 32'd17);
    check("mul1.stall_cycles", stalls, 33);
    check("mul1.rw_pulses", pulses, 0);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, stalls, pulses);
    check("mul2.product", aluoutM, 32'd1);

    // Operand isolation
    do_mul(32'd6, 32'd7, 1'b1, stalls, pulses);
    check("mul_iso.product", aluoutM, 32'd42);
    check("mul_iso.stall_cycles", stalls, 33);

    // Abort by flush at BUSY count 10
    set_alu(3'b010, 32'd9, 32'd9);
    mulE = 1'b1;
    pulses = 0;
    step();                          // accept
    for (int i = 0; i < 10; i++) begin
      step();
      if (regwriteM) pulses++;
    end
    flushE = 1'b1;
    step();
    if (regwriteM) pulses++;
    set_alu(3'b110, 32'd50, 32'd8);
    #2;
    check("abort.stall_after", {31'd0, stallE}, 32'd0);
    check("abort.rw_pulses", pulses, 0);
    step();
    check("abort.next_sub", aluoutM, 32'd42);

    // Reset mid-multiply
    set_alu(3'b010, 32'd11, 32'd13);
    mulE = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    mulE = 1'b0;
    reset_pulse();
    set_alu(3'b010, 32'd2, 32'd3);
    step();
    check("post_reset.add", aluoutM, 32'd5);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
